// File: rtl/mathbox_sequencer_pkg.sv
// rtl/mathbox_sequencer_pkg.sv - shared math-box types and default widths
package mathbox_sequencer_pkg;

  localparam int PC_W_DEF = 8;
  localparam int WD_W_DEF = 10;

  typedef enum logic [1:0] {
    JC_ALWAYS = 2'b00,
    JC_S1     = 2'b01,
    JC_S0     = 2'b10,
    JC_NEVER  = 2'b11
  } jcond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mb_jump_cond.sv
// rtl/mb_jump_cond.sv - combinational evaluator of the microcode jump condition
module mb_jump_cond
  import mathbox_sequencer_pkg::*;
(
  input  logic [1:0] jcond,
  input  logic       s0,
  input  logic       s1,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (jcond_e'(jcond))
      JC_ALWAYS: cond_true = 1'b1;
      JC_S1:     cond_true = s1;
      JC_S0:     cond_true = s0;
      JC_NEVER:  cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/mathbox_sequencer.sv
// rtl/mathbox_sequencer.sv - math-box microcode sequencer with start latch and watchdog
module mathbox_sequencer
  import mathbox_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int WD_W = WD_W_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            MB_WR,
  input  logic [7:0]      MB_DATA,
  input  logic [PC_W-1:0] START_ADDR,
  input  logic            STOP,
  input  logic            JUMP,
  input  logic [1:0]      JCOND,
  input  logic [PC_W-1:0] JMP_ADDR,
  input  logic            S0,
  input  logic            S1,
  output logic [PC_W-1:0] PC,
  output logic [7:0]      EDB_IN,
  output logic            RUN_EN,
  output logic            BUSY,
  output logic            TIMEOUT
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      edb_q, edb_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            cond_true;

  mb_jump_cond u_jump_cond (
    .jcond     (JCOND),
    .s0        (S0),
    .s1        (S1),
    .cond_true (cond_true)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      edb_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      edb_q     <= edb_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    edb_d     = edb_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (MB_WR) begin
          state_d   = ST_RUN;
          pc_d      = START_ADDR;
          edb_d     = MB_DATA;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        // STOP outranks both the watchdog and any jump; the PC freezes on exit
        if (STOP) begin
          state_d = ST_IDLE;
          wd_d    = '0;
        end else if (&wd_q) begin
          state_d   = ST_IDLE;
          wd_d      = '0;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_ONE;
          pc_d = (JUMP && cond_true) ? JMP_ADDR : pc_q + PC_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign PC      = pc_q;
  assign EDB_IN  = edb_q;
  assign RUN_EN  = (state_q == ST_RUN);
  assign BUSY    = (state_q == ST_RUN);
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_mathbox_sequencer.sv
// tb/tb_mathbox_sequencer.sv - directed and randomized bench for mathbox_sequencer
module tb_mathbox_sequencer;

  localparam int WD_LIMIT = 16;

  logic       CLK = 1'b0;
  logic       RST_N, MB_WR, STOP, JUMP, S0, S1;
  logic [7:0] MB_DATA, START_ADDR, JMP_ADDR;
  logic [1:0] JCOND;
  logic [7:0] PC, EDB_IN;
  logic       RUN_EN, BUSY, TIMEOUT;

  mathbox_sequencer #(.PC_W(8), .WD_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .MB_WR(MB_WR), .MB_DATA(MB_DATA),
    .START_ADDR(START_ADDR), .STOP(STOP), .JUMP(JUMP), .JCOND(JCOND),
    .JMP_ADDR(JMP_ADDR), .S0(S0), .S1(S1), .PC(PC), .EDB_IN(EDB_IN),
    .RUN_EN(RUN_EN), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // microcode ROM image, looked up by the bench at the model's PC
  bit       rom_stop  [256];
  bit       rom_jump  [256];
  bit [1:0] rom_jcond [256];
  bit [7:0] rom_jaddr [256];

  // reference model: running flag, PC, latched data, cycles spent in the run, timeout flag
  bit     m_run;
  int     m_pc;
  int     m_edb;
  int     m_cycles;
  bit     m_to;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 256; i++) begin
      rom_stop[i] = 0; rom_jump[i] = 0; rom_jcond[i] = 2'b00; rom_jaddr[i] = 8'h00;
    end
  endtask

  task automatic load_rom();
    STOP     = rom_stop[m_pc];
    JUMP     = rom_jump[m_pc];
    JCOND    = rom_jcond[m_pc];
    JMP_ADDR = rom_jaddr[m_pc];
  endtask

  task automatic step();
    bit taken;
    bit n_run; int n_pc; int n_edb; int n_cycles; bit n_to;
    n_run = m_run; n_pc = m_pc; n_edb = m_edb; n_cycles = m_cycles; n_to = m_to;
    taken = JUMP && ((JCOND == 2'd0) || (JCOND == 2'd1 && S1) || (JCOND == 2'd2 && S0));
    if (!RST_N) begin
      n_run = 0; n_pc = 0; n_edb = 0; n_cycles = 0; n_to = 0;
    end else if (!m_run) begin
      if (MB_WR) begin
        n_run = 1; n_pc = START_ADDR; n_edb = MB_DATA; n_cycles = 0; n_to = 0;
      end
    end else if (STOP) begin
      n_run = 0; n_cycles = 0;
    end else if (m_cycles + 1 == WD_LIMIT) begin
      n_run = 0; n_cycles = 0; n_to = 1;
    end else begin
      n_cycles = m_cycles + 1;
      n_pc = taken ? int'(JMP_ADDR) : (m_pc + 1) % 256;
    end
    @(posedge CLK);
    #1;
    m_run = n_run; m_pc = n_pc; m_edb = n_edb; m_cycles = n_cycles; m_to = n_to;
    chk("pc", PC, m_pc);
    chk("edb_in", EDB_IN, m_edb);
    chk("run_en", RUN_EN, m_run);
    chk("busy", BUSY, m_run);
    chk("timeout", TIMEOUT, m_to);
    MB_WR = 1'b0;
    load_rom();
  endtask

  task automatic start(input logic [7:0] addr, input logic [7:0] data);
    START_ADDR = addr; MB_DATA = data; MB_WR = 1'b1;
    step();
  endtask

  initial begin
    RST_N = 1'b0; MB_WR = 1'b1; MB_DATA = 8'hFF; START_ADDR = 8'h55;
    STOP = 0; JUMP = 0; JCOND = 2'b00; JMP_ADDR = 8'h00; S0 = 0; S1 = 0;
    m_run = 0; m_pc = 0; m_edb = 0; m_cycles = 0; m_to = 0;
    clr_rom();

    // reset dominates a coincident write
    step();
    chk("rst_pc", PC, 8'h00);
    chk("rst_edb", EDB_IN, 8'h00);
    chk("rst_busy", {RUN_EN, BUSY, TIMEOUT}, 3'b000);
    RST_N = 1'b1;
    step();

    // start at 0x20, stop at 0x23
    rom_stop[8'h23] = 1;
    start(8'h20, 8'hA5);
    chk("ss_pc0", PC, 8'h20);
    chk("ss_edb", EDB_IN, 8'hA5);
    step(); chk("ss_pc1", PC, 8'h21);
    step(); chk("ss_pc2", PC, 8'h22);
    step(); chk("ss_pc3", PC, 8'h23);
    chk("ss_busy3", BUSY, 1'b1);
    step();
    chk("ss_done_busy", BUSY, 1'b0);
    chk("ss_done_pc", PC, 8'h23);

    // conditional jump on S1 taken, not taken, and JCOND=never
    clr_rom();
    rom_jump[8'h10] = 1; rom_jcond[8'h10] = 2'b01; rom_jaddr[8'h10] = 8'h40;
    rom_stop[8'h40] = 1; rom_stop[8'h11] = 1;
    S1 = 1'b1;
    start(8'h10, 8'h01);
    step(); chk("jmp_s1", PC, 8'h40);
    step();
    S1 = 1'b0;
    start(8'h10, 8'h02);
    step(); chk("jmp_s1_low", PC, 8'h11);
    step();
    rom_jcond[8'h10] = 2'b11; S0 = 1'b1; S1 = 1'b1;
    start(8'h10, 8'h03);
    step(); chk("jmp_never", PC, 8'h11);
    step();
    S0 = 1'b0; S1 = 1'b0;

    // wrap past 0xFF with a write arriving mid-run
    clr_rom();
    rom_stop[8'h00] = 1;
    start(8'hFE, 8'h5A);
    step(); chk("wrap_ff", PC, 8'hFF);
    MB_WR = 1'b1; MB_DATA = 8'h3C;
    step(); chk("wrap_00", PC, 8'h00);
    chk("wrap_edb", EDB_IN, 8'h5A);
    step();

    // watchdog expiry after 16 run cycles
    clr_rom();
    start(8'h80, 8'h11);
    for (int i = 1; i < WD_LIMIT; i++) step();
    chk("wd_last_pc", PC, 8'h8F);
    chk("wd_still_busy", BUSY, 1'b1);
    step();
    chk("wd_timeout", TIMEOUT, 1'b1);
    chk("wd_idle", BUSY, 1'b0);
    chk("wd_hold_pc", PC, 8'h8F);
    rom_stop[8'h90] = 1;
    start(8'h90, 8'h22);
    chk("wd_clear", TIMEOUT, 1'b0);
    step();

    // STOP with JUMP, plus a coincident write, then STOP on the final watchdog cycle
    clr_rom();
    rom_stop[8'h30] = 1; rom_jump[8'h30] = 1; rom_jcond[8'h30] = 2'b00; rom_jaddr[8'h30] = 8'h77;
    start(8'h30, 8'h44);
    MB_WR = 1'b1; MB_DATA = 8'h99; START_ADDR = 8'h12;
    step();
    chk("sj_pc", PC, 8'h30);
    chk("sj_edb", EDB_IN, 8'h44);
    chk("sj_busy", BUSY, 1'b0);
    clr_rom();
    rom_stop[8'h4F] = 1;
    start(8'h40, 8'h66);
    for (int i = 0; i < WD_LIMIT; i++) step();
    chk("wdstop_to", TIMEOUT, 1'b0);
    chk("wdstop_pc", PC, 8'h4F);

    // reset mid-run with a write in the same cycle
    clr_rom();
    start(8'hC0, 8'h77);
    step();
    RST_N = 1'b0; MB_WR = 1'b1;
    step();
    chk("rst_mid", {RUN_EN, BUSY, PC}, 10'h000);
    RST_N = 1'b1;

    // randomized programs and traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) begin
        for (int i = 0; i < 256; i++) begin
          rom_stop[i]  = ($urandom_range(0, 5) == 0);
          rom_jump[i]  = ($urandom_range(0, 3) == 0);
          rom_jcond[i] = 2'($urandom_range(0, 3));
          rom_jaddr[i] = 8'($urandom);
        end
        load_rom();
      end
      RST_N      = ($urandom_range(0, 60) != 0);
      MB_WR      = ($urandom_range(0, 3) == 0);
      MB_DATA    = 8'($urandom);
      START_ADDR = 8'($urandom);
      S0         = 1'($urandom);
      S1         = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mathbox_sequencer.md
MATHBOX_SEQUENCER -- requirements
Module: mathbox_sequencer

Interface
REQ-001 Parameter PC_W, default 8: microcode program-counter width.
REQ-002 Parameter WD_W, default 10: watchdog step-counter width.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  one clock; reset is synchronous and active-low.
REQ-005 MB_WR  input  1  CPU write strobe to math box; one CLK-cycle pulse.
REQ-006 MB_DATA  input  8  CPU write data.
REQ-007 START_ADDR  input  PC_W  start-address ROM output; the ROM is indexed externally by CPU address bits.
REQ-008 STOP  input  1  microcode stop bit for the current PC.
REQ-009 JUMP  input  1  microcode jump-enable bit for the current PC.
REQ-010 JCOND  input  2  jump condition: 00 always, 01 S1, 10 S0, 11 never.
REQ-011 JMP_ADDR  input  PC_W  microcode jump target.
REQ-012 S0 / S1  input  1 each  ALU overflow and F3 status from the ALU stage.
REQ-013 PC  output  PC_W  address to the L1/K1/J/H1/F1 microcode ROMs.
REQ-014 EDB_IN  output  8  latched CPU data presented to the ALU D inputs.
REQ-015 RUN_EN  output  1  high while the ALU executes microcode.
REQ-016 BUSY  output  1  math-box status, CPU-readable; high = not done.
REQ-017 TIMEOUT  output  1  sticky watchdog flag.

Function
REQ-018 Two states: IDLE and RUN. RUN_EN and BUSY are high only in RUN.
REQ-019 IDLE plus MB_WR: the next edge SHALL load PC<=START_ADDR, load EDB_IN<=MB_DATA, clear the watchdog and TIMEOUT, and enter RUN.
REQ-020 The first microinstruction SHALL execute in the cycle after MB_WR, giving 1-cycle start latency.
REQ-021 RUN, STOP=0, jump taken: PC<=JMP_ADDR. A jump is taken when JUMP=1 and JCOND evaluates true against S0/S1 in the same cycle.
REQ-022 RUN, STOP=0, no jump: PC<=PC+1 modulo 2^PC_W; 0xFF wraps to 0x00 without error.
REQ-023 RUN, STOP=1: the next state SHALL be IDLE, and STOP SHALL take priority over JUMP. The PC holds its value and BUSY falls on the next edge.
REQ-024 The watchdog SHALL increment once per RUN cycle. At all-ones it forces IDLE and sets TIMEOUT. If STOP is also asserted in that cycle, STOP wins and TIMEOUT stays 0.
REQ-025 MB_WR during RUN SHALL be ignored: PC, EDB_IN and the watchdog are unaffected.
REQ-026 MB_WR in the same cycle that STOP returns the block to IDLE SHALL be ignored.
REQ-027 In IDLE, PC and EDB_IN SHALL hold their values and the watchdog SHALL hold at 0.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 With RST_N=0 at an edge: state=IDLE, PC=0, EDB_IN=0x00, watchdog=0, RUN_EN=0, BUSY=0, TIMEOUT=0.
REQ-030 Reset asserted mid-RUN SHALL abort the run on that edge. MB_WR in the same cycle SHALL be ignored.

Structure
REQ-031 The shared math-box package SHALL hold the JCOND encodings, the state enum and the PC_W/WD_W defaults.
REQ-032 One sub-module is natural: mb_jump_cond, a purely combinational evaluator of JCOND, S0 and S1. Everything else SHALL be flat.

Verification
REQ-033 Reset: MB_WR plus RST_N=0 -> all outputs 0 next edge, state IDLE.
REQ-034 Start/stop: START_ADDR=0x20, MB_DATA=0xA5, STOP asserted at PC=0x23 -> PC 0x20,21,22,23; EDB_IN=0xA5; BUSY high 4 cycles, then 0 with PC=0x23.
REQ-035 Conditional jump: PC=0x10, JUMP=1, JCOND=01, S1=1 -> PC=JMP_ADDR=0x40. Repeat with S1=0 -> PC=0x11. JCOND=11 -> never jumps.
REQ-036 Wrap and collision: start at 0xFE -> PC 0xFE,0xFF,0x00. A second MB_WR (MB_DATA=0x3C) at PC=0xFF leaves EDB_IN unchanged.
REQ-037 Watchdog: WD_W=4, STOP never asserted -> forced IDLE after 16 RUN cycles with TIMEOUT=1. The next MB_WR clears TIMEOUT.
REQ-038 STOP plus JUMP together, and STOP on the watchdog's final cycle -> IDLE, PC unchanged, TIMEOUT=0.
